// File: rtl/add_share_arbiter_pkg.sv
// Shared types and helpers for the time-shared adder arbiter.
// Holds the FSM state encoding and the requester-ID width function.
package add_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // A single requester-ID bit is kept even where clog2 would give zero.
  function automatic int calc_id_w(input int nreq);
    return (nreq > 2) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/add_share_arbiter_if.sv
// Request/response bundle between the requesters, the consumer and the shared adder.
// The master modport is the requester/consumer side; the slave modport is the arbiter.
interface add_share_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8
) ();
  import add_arb_pkg::*;

  localparam int ID_W = calc_id_w(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_ready;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, busy
  );

endinterface

// File: rtl/add_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit after last_grant,
// wrapping around, reported as one-hot, as an index and as an any flag.
module rr_pick
  import add_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int ID_W = calc_id_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_last_grant,
  output logic [NREQ-1:0] o_onehot,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  // Scan from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    logic [ID_W-1:0] w_cand;
    w_cand = '0;
    o_idx  = '0;
    for (int off = NREQ; off >= 1; off--) begin
      w_cand = ID_W'((int'(i_last_grant) + off) % NREQ);
      o_idx  = i_req[w_cand] ? w_cand : o_idx;
    end
    o_any    = |i_req;
    o_onehot = o_any ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/add_share_arbiter.sv
// One registered WIDTH-bit adder shared by NREQ requesters through a
// round-robin grant; results return tagged with the owning requester ID.
module add_share_arbiter
  import add_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  add_share_arbiter_if.slave bus
);

  localparam int ID_W = calc_id_w(NREQ);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_last_grant;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_carry;
  logic [ID_W-1:0]  r_rsp_id;

  logic [NREQ-1:0]  w_pick_onehot;
  logic [ID_W-1:0]  w_pick_idx;
  logic             w_pick_any;
  logic [NREQ-1:0]  w_req_ready;
  logic [WIDTH-1:0] w_a_arr [NREQ];
  logic [WIDTH-1:0] w_b_arr [NREQ];
  logic [WIDTH:0]   w_sum_ext;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
    assign w_b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_onehot     (w_pick_onehot),
    .o_idx        (w_pick_idx),
    .o_any        (w_pick_any)
  );

  assign w_sum_ext = {1'b0, r_a} + {1'b0, r_b};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = w_pick_any ? EXEC : IDLE;
      EXEC:    w_next_state = RESP;
      RESP:    w_next_state = (r_rsp_valid && bus.rsp_ready) ? IDLE : RESP;
      default: w_next_state = IDLE;
    endcase
  end

  // Grant is offered only while idle, so nothing is accepted with a result outstanding.
  always_comb begin
    w_req_ready = '0;
    if (r_state == IDLE) begin
      w_req_ready = w_pick_onehot;
    end else begin
      w_req_ready = '0;
    end
  end

  // Operand capture, grant history and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= '0;
      r_last_grant <= ID_W'(NREQ - 1);
      r_rsp_valid  <= 1'b0;
      r_rsp_sum    <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_id     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_a          <= w_a_arr[w_pick_idx];
            r_b          <= w_b_arr[w_pick_idx];
            r_id         <= w_pick_idx;
            r_last_grant <= w_pick_idx;
          end
        end
        EXEC: begin
          r_rsp_sum   <= w_sum_ext[WIDTH-1:0];
          r_rsp_carry <= w_sum_ext[WIDTH];
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_sum   = r_rsp_sum;
  assign bus.rsp_carry = r_rsp_carry;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter (NREQ=2, WIDTH=8): inputs driven and
// outputs sampled on the falling edge, expected values computed by hand.
module tb_add_share_arbiter;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  add_share_arbiter_if #(.NREQ(2), .WIDTH(8)) bus ();

  add_share_arbiter #(.NREQ(2), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00; bus.req_a = 16'd0; bus.req_b = 16'd0; bus.rsp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_sum !== 8'd0) begin errors++; $display("FAIL reset_rsp_sum: got %0d want 0", bus.rsp_sum); end
    checks++; if (bus.rsp_carry !== 1'b0) begin errors++; $display("FAIL reset_rsp_carry: got %b want 0", bus.rsp_carry); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b want 0", bus.rsp_id); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    bus.req_a = {8'd0, 8'd3}; bus.req_b = {8'd0, 8'd4}; bus.req_valid = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", bus.req_ready); end
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL single_ready_exec: got %b want 00", bus.req_ready); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_exec: got %b want 1", bus.busy); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b want 0", bus.rsp_valid); end
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_sum !== 8'd7) begin errors++; $display("FAIL single_sum: got %0d want 7", bus.rsp_sum); end
    checks++; if (bus.rsp_carry !== 1'b0) begin errors++; $display("FAIL single_carry: got %b want 0", bus.rsp_carry); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b want 0", bus.rsp_id); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_clear: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", bus.busy); end
    checks++; if (bus.rsp_sum !== 8'd7) begin errors++; $display("FAIL single_sum_hold: got %0d want 7", bus.rsp_sum); end
  endtask

  task automatic test_carry();
    bus.rsp_ready = 1'b1;
    bus.req_a = {8'd200, 8'd0}; bus.req_b = {8'd100, 8'd0}; bus.req_valid = 2'b10;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL carry1_grant: got %b want 10", bus.req_ready); end
    @(negedge clk); bus.req_valid = 2'b00;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL carry1_valid: got %b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_sum !== 8'd44) begin errors++; $display("FAIL carry1_sum: got %0d want 44", bus.rsp_sum); end
    checks++; if (bus.rsp_carry !== 1'b1) begin errors++; $display("FAIL carry1_carry: got %b want 1", bus.rsp_carry); end
    checks++; if (bus.rsp_id !== 1'b1) begin errors++; $display("FAIL carry1_id: got %b want 1", bus.rsp_id); end
    @(negedge clk);
    bus.req_a = {8'd0, 8'd255}; bus.req_b = {8'd0, 8'd1}; bus.req_valid = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL carry2_grant: got %b want 01", bus.req_ready); end
    @(negedge clk); bus.req_valid = 2'b00;
    @(negedge clk);
    checks++; if (bus.rsp_sum !== 8'd0) begin errors++; $display("FAIL carry2_sum: got %0d want 0", bus.rsp_sum); end
    checks++; if (bus.rsp_carry !== 1'b1) begin errors++; $display("FAIL carry2_carry: got %b want 1", bus.rsp_carry); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL carry2_id: got %b want 0", bus.rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_oh;
    logic [7:0] exp_sum;
    logic       exp_id;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_a = {8'd10, 8'd1}; bus.req_b = {8'd20, 8'd2}; bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_id  = (i % 2 == 1) ? 1'b1 : 1'b0;
      exp_oh  = exp_id ? 2'b10 : 2'b01;
      exp_sum = exp_id ? 8'd30 : 8'd3;
      #1;
      checks++; if (bus.req_ready !== exp_oh) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, bus.req_ready, exp_oh); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_idle_valid[%0d]: got %b want 0", i, bus.rsp_valid); end
      @(negedge clk);
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rr_exec_ready[%0d]: got %b want 00", i, bus.req_ready); end
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
      checks++; if (bus.rsp_id !== exp_id) begin errors++; $display("FAIL rr_id[%0d]: got %b want %b", i, bus.rsp_id, exp_id); end
      checks++; if (bus.rsp_sum !== exp_sum) begin errors++; $display("FAIL rr_sum[%0d]: got %0d want %0d", i, bus.rsp_sum, exp_sum); end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    bus.req_a = {8'd5, 8'd50}; bus.req_b = {8'd6, 8'd60}; bus.req_valid = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_grant: got %b want 01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b10;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_exec_ready: got %b want 00", bus.req_ready); end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
      checks++; if (bus.rsp_sum !== 8'd110) begin errors++; $display("FAIL bp_sum[%0d]: got %0d want 110", i, bus.rsp_sum); end
      checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL bp_id[%0d]: got %b want 0", i, bus.rsp_id); end
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 00", i, bus.req_ready); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %b want 1", i, bus.busy); end
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_handshake_ready: got %b want 00", bus.req_ready); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_transfer_once: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b want 0", bus.busy); end
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant: got %b want 10", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++; if (bus.rsp_id !== 1'b1) begin errors++; $display("FAIL bp_next_id: got %b want 1", bus.rsp_id); end
    checks++; if (bus.rsp_sum !== 8'd11) begin errors++; $display("FAIL bp_next_sum: got %0d want 11", bus.rsp_sum); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b1;
    bus.req_a = {8'd0, 8'd10}; bus.req_b = {8'd0, 8'd20}; bus.req_valid = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rm_grant: got %b want 01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_valid_async: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy_async: got %b want 0", bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_rsp[%0d]: got %b want 0", i, bus.rsp_valid); end
    end
    bus.req_a = {8'd40, 8'd30}; bus.req_b = {8'd2, 8'd1}; bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rm_first_grant: got %b want 01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL rm_id: got %b want 0", bus.rsp_id); end
    checks++; if (bus.rsp_sum !== 8'd31) begin errors++; $display("FAIL rm_sum: got %0d want 31", bus.rsp_sum); end
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    bus.rsp_ready = 1'b0;
    bus.req_a = {8'd0, 8'd7}; bus.req_b = {8'd0, 8'd8}; bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    bus.req_valid = 2'b10;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL wd_ready0: got %b want 00", bus.req_ready); end
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL wd_ready1: got %b want 00", bus.req_ready); end
    bus.req_valid = 2'b00;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL wd_valid: got %b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL wd_id: got %b want 0", bus.rsp_id); end
    checks++; if (bus.rsp_sum !== 8'd15) begin errors++; $display("FAIL wd_sum: got %0d want 15", bus.rsp_sum); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL wd_no_rsp[%0d]: got %b want 0", i, bus.rsp_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wd_idle[%0d]: got %b want 0", i, bus.busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_withdraw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
